// File: rtl/phys_free_list.sv
// Circular free list of physical register indices for rename. The speculative
// head serves allocation; the committed head lets a flush restore it in one cycle.
module phys_free_list #(
    parameter int unsigned  NUM_PHYS        = 64,
    parameter int unsigned  NUM_ARCH        = 32,
    parameter bit           ASSERT_OVERFLOW = 1'b1,
    localparam int unsigned DEPTH           = NUM_PHYS - NUM_ARCH,
    localparam int unsigned PW              = $clog2(NUM_PHYS),
    localparam int unsigned AW              = $clog2(DEPTH),
    localparam int unsigned CW              = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dequeue,
    output logic [PW-1:0] deq_pd,
    output logic          empty,
    input  logic          enqueue,
    input  logic [PW-1:0] enq_pd,
    input  logic          commit_alloc,
    input  logic          flush,
    output logic [CW-1:0] count
);

    logic [PW-1:0] mem [DEPTH];
    logic [CW-1:0] spec_head;
    logic [CW-1:0] cmt_head;
    logic [CW-1:0] tail;
    logic [CW-1:0] spec_next;
    logic [CW-1:0] cmt_next;
    logic          full;
    logic          do_deq;
    logic          enq_ok;
    logic          do_enq;
    logic          overflow_drop;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    always_comb begin
        count         = tail - spec_head;
        empty         = (count == '0);
        full          = (tail[AW-1:0] == spec_head[AW-1:0]) && (tail[AW] != spec_head[AW]);
        deq_pd        = mem[spec_head[AW-1:0]];
        do_deq        = dequeue && !empty && !flush;
        enq_ok        = enqueue && (enq_pd != '0);
        do_enq        = enq_ok && !full;
        overflow_drop = enq_ok && full;
        cmt_next      = cmt_head + CW'(commit_alloc);
        // Flush recovery uses the committed head including this cycle's commit.
        spec_next     = flush ? cmt_next : (spec_head + CW'(do_deq));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= PW'(NUM_ARCH + i);
            end
            spec_head <= '0;
            cmt_head  <= '0;
            tail      <= CW'(DEPTH);
        end else begin
            if (do_enq) begin
                mem[tail[AW-1:0]] <= enq_pd;
                tail              <= tail + CW'(1);
            end
            spec_head <= spec_next;
            cmt_head  <= cmt_next;
        end
    end

    if (ASSERT_OVERFLOW) begin : g_ovf_chk
        a_no_overflow: assert property (@(posedge clk) disable iff (rst) !overflow_drop);
    end

    a_cmt_not_past_spec: assert property (@(posedge clk) disable iff (rst)
        !(commit_alloc && (cmt_head == spec_head) && !do_deq));

endmodule
